// File: rtl/design_select_ctrl_if.sv
// Host-side handshake bundle for design_select_ctrl: select requests in, status out.
interface design_select_ctrl_if;
  logic       req_valid;
  logic [5:0] req_sel;
  logic       req_reset_only;
  logic       hold_mode;
  logic       req_ready;
  logic       busy;
  logic       err_unpop;
  logic [7:0] switch_count;

  modport master (
    output req_valid, req_sel, req_reset_only, hold_mode,
    input  req_ready, busy, err_unpop, switch_count
  );

  modport slave (
    input  req_valid, req_sel, req_reset_only, hold_mode,
    output req_ready, busy, err_unpop, switch_count
  );
endinterface

// File: rtl/design_select_ctrl.sv
// Sequences a safe switch of the active design slot: blank outputs, change des_sel,
// hold the new design in reset, settle, then re-enable the multiplexer outputs.
module design_select_ctrl #(
  parameter logic [5:0]  DEFAULT_SEL    = 6'd1,
  parameter logic [63:0] POPULATED_MASK = 64'h0000_0FFF_FFFF_F83E,
  parameter int unsigned DRAIN_CYCLES   = 2,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  design_select_ctrl_if.slave  host,
  output logic [5:0]           des_sel,
  output logic                 hold_if_not_sel,
  output logic                 des_rst,
  output logic                 io_out_en
);

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {StIdle, StDrain, StReset, StSettle} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      pend_sel_q, pend_sel_d;
  logic            pend_hold_q, pend_hold_d;
  logic [5:0]      des_sel_q, des_sel_d;
  logic            hold_q, hold_d;
  logic            des_rst_q, des_rst_d;
  logic            io_out_en_q, io_out_en_d;
  logic            err_q, err_d;
  logic [7:0]      count_q, count_d;

  logic accept;
  logic unpop;

  assign accept = host.req_valid & (state_q == StIdle);
  // A reset-only request targets the current slot, which is always considered valid.
  assign unpop  = ~host.req_reset_only & ~POPULATED_MASK[host.req_sel];

  // State register and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pend_sel_q  <= DEFAULT_SEL;
      pend_hold_q <= 1'b0;
      des_sel_q   <= DEFAULT_SEL;
      hold_q      <= 1'b0;
      des_rst_q   <= 1'b0;
      io_out_en_q <= 1'b1;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_sel_q  <= pend_sel_d;
      pend_hold_q <= pend_hold_d;
      des_sel_q   <= des_sel_d;
      hold_q      <= hold_d;
      des_rst_q   <= des_rst_d;
      io_out_en_q <= io_out_en_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  // Next-state logic; each state loads its own window length minus one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !unpop) begin
          state_d = StDrain;
          cnt_d   = CntW'(DRAIN_CYCLES - 1);
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StReset;
          cnt_d   = CntW'(RST_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StReset: begin
        if (cnt_q == '0) begin
          state_d = StSettle;
          cnt_d   = CntW'(SETTLE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs, derived from the transition.
  always_comb begin
    pend_sel_d  = pend_sel_q;
    pend_hold_d = pend_hold_q;
    des_sel_d   = des_sel_q;
    hold_d      = hold_q;
    count_d     = count_q;
    io_out_en_d = (state_d == StIdle);
    des_rst_d   = (state_d == StReset);
    err_d       = accept & unpop;

    if (accept) begin
      pend_sel_d  = host.req_reset_only ? des_sel_q : host.req_sel;
      pend_hold_d = host.hold_mode;
    end

    if (state_q == StDrain && state_d == StReset) begin
      des_sel_d = pend_sel_q;
      hold_d    = pend_hold_q;
    end

    if (state_q == StSettle && state_d == StIdle) begin
      count_d = count_q + 8'd1;
    end
  end

  assign host.req_ready    = (state_q == StIdle);
  assign host.busy         = (state_q != StIdle);
  assign host.err_unpop    = err_q;
  assign host.switch_count = count_q;

  assign des_sel         = des_sel_q;
  assign hold_if_not_sel = hold_q;
  assign des_rst         = des_rst_q;
  assign io_out_en       = io_out_en_q;

endmodule

// File: tb/tb_design_select_ctrl.sv
// Directed bench for design_select_ctrl with hand-computed expectations (default parameters).
module tb_design_select_ctrl;

  logic       clock;
  logic       reset;
  logic [5:0] des_sel;
  logic       hold_if_not_sel;
  logic       des_rst;
  logic       io_out_en;

  int unsigned checks;
  int unsigned failures;

  design_select_ctrl_if host ();

  design_select_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .host            (host.slave),
    .des_sel         (des_sel),
    .hold_if_not_sel (hold_if_not_sel),
    .des_rst         (des_rst),
    .io_out_en       (io_out_en)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_ready(input string tag, input int budget);
    int k;
    k = 0;
    while (!host.req_ready && k < budget) begin
      step();
      k++;
    end
    if (!host.req_ready) check(tag, 64'(host.req_ready), 64'd1);
  endtask

  logic t6_sel_ok;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    host.req_valid      = 1'b0;
    host.req_sel        = 6'd0;
    host.req_reset_only = 1'b0;
    host.hold_mode      = 1'b0;
    #22;
    reset = 1'b1;
    step(2);

    // 1: reset state
    check("t1_des_sel",   64'(des_sel),           64'd1);
    check("t1_io_out_en", 64'(io_out_en),         64'd1);
    check("t1_des_rst",   64'(des_rst),           64'd0);
    check("t1_ready",     64'(host.req_ready),    64'd1);
    check("t1_count",     64'(host.switch_count), 64'd0);
    check("t1_hold",      64'(hold_if_not_sel),   64'd0);

    // 3: unpopulated slot 7
    host.req_valid = 1'b1;
    host.req_sel   = 6'd7;
    step();
    host.req_valid = 1'b0;
    check("t3_err_pulse", 64'(host.err_unpop),    64'd1);
    check("t3_ready",     64'(host.req_ready),    64'd1);
    check("t3_io",        64'(io_out_en),         64'd1);
    step();
    check("t3_err_clear", 64'(host.err_unpop),    64'd0);
    check("t3_des_sel",   64'(des_sel),           64'd1);
    check("t3_count",     64'(host.switch_count), 64'd0);

    // 2 + 4: switch to slot 12, with slot 20 held pending while busy
    host.req_valid = 1'b1;
    host.req_sel   = 6'd12;
    host.hold_mode = 1'b1;
    step();                                   // E0
    host.req_sel   = 6'd20;
    host.hold_mode = 1'b0;
    check("t2_e0_io",    64'(io_out_en),      64'd0);
    check("t2_e0_ready", 64'(host.req_ready), 64'd0);
    check("t2_e0_busy",  64'(host.busy),      64'd1);
    step();                                   // E1
    check("t2_e1_sel",   64'(des_sel),        64'd1);
    check("t2_e1_rst",   64'(des_rst),        64'd0);
    step();                                   // E2
    check("t2_e2_sel",   64'(des_sel),        64'd12);
    check("t2_e2_rst",   64'(des_rst),        64'd1);
    check("t2_e2_hold",  64'(hold_if_not_sel), 64'd1);
    step(3);                                  // E5
    check("t2_e5_rst",   64'(des_rst),        64'd1);
    step();                                   // E6
    check("t2_e6_rst",   64'(des_rst),        64'd0);
    check("t2_e6_io",    64'(io_out_en),      64'd0);
    step();                                   // E7
    check("t2_e7_io",    64'(io_out_en),      64'd0);
    check("t2_e7_count", 64'(host.switch_count), 64'd0);
    step();                                   // E8
    check("t2_e8_io",    64'(io_out_en),      64'd1);
    check("t2_e8_count", 64'(host.switch_count), 64'd1);
    check("t4_e8_ready", 64'(host.req_ready), 64'd1);
    check("t4_e8_sel",   64'(des_sel),        64'd12);
    step();                                   // held request accepted here
    host.req_valid = 1'b0;
    check("t4_accept_ready", 64'(host.req_ready), 64'd0);
    check("t4_accept_io",    64'(io_out_en),      64'd0);
    step(2);
    check("t4_sel_switch", 64'(des_sel), 64'd20);
    wait_ready("t4_timeout", 20);
    check("t4_final_sel",   64'(des_sel),           64'd20);
    check("t4_final_count", 64'(host.switch_count), 64'd2);
    check("t4_final_hold",  64'(hold_if_not_sel),   64'd0);
    check("t4_final_io",    64'(io_out_en),         64'd1);

    // 5: reset asserted mid-switch to slot 30
    host.req_valid = 1'b1;
    host.req_sel   = 6'd30;
    step();                                   // E0
    host.req_valid = 1'b0;
    step(3);                                  // E3
    check("t5_e3_sel", 64'(des_sel), 64'd30);
    check("t5_e3_rst", 64'(des_rst), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t5_async_sel",   64'(des_sel),           64'd1);
    check("t5_async_rst",   64'(des_rst),           64'd0);
    check("t5_async_io",    64'(io_out_en),         64'd1);
    check("t5_async_ready", 64'(host.req_ready),    64'd1);
    check("t5_async_count", 64'(host.switch_count), 64'd0);
    step();
    reset = 1'b1;
    step(10);
    check("t5_after_sel", 64'(des_sel),   64'd1);
    check("t5_after_io",  64'(io_out_en), 64'd1);

    // 6: 256 reset-only requests; req_sel is a different populated slot and must be ignored
    t6_sel_ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      host.req_valid      = 1'b1;
      host.req_reset_only = 1'b1;
      host.req_sel        = 6'd33;
      step();
      host.req_valid = 1'b0;
      for (int k = 0; k < 20 && !host.req_ready; k++) begin
        if (des_sel !== 6'd1) t6_sel_ok = 1'b0;
        step();
      end
      if (!host.req_ready) begin
        check("t6_timeout", 64'(host.req_ready), 64'd1);
        break;
      end
      if (des_sel !== 6'd1) t6_sel_ok = 1'b0;
      if (i == 254) check("t6_count_255", 64'(host.switch_count), 64'd255);
    end
    host.req_reset_only = 1'b0;
    check("t6_sel_stable", 64'(t6_sel_ok),          64'd1);
    check("t6_count_wrap", 64'(host.switch_count), 64'd0);
    check("t6_io",         64'(io_out_en),         64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
